// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: pipelined inst-SRAM requests feeding a QDEPTH-entry decode queue.
// Define IFQ_BYPASS_EN to forward a return straight to decode in the same cycle when the queue is empty.
module if_fetch_queue #(
  parameter int          QDEPTH          = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] fetch_pc_vrtl,
  input  logic [31:0] fetch_pa,
  input  logic        fetch_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ds_allowin,
  output logic        fs2ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adef
);

  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int IW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int DW  = $clog2(2 * MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0]  MAX_IF = IW'(MAX_OUTSTANDING);
  localparam logic [CW:0]    QFULL  = (CW + 1)'(QDEPTH);
  localparam logic [FAW-1:0] FLAST  = FAW'(MAX_OUTSTANDING - 1);

  logic [31:0]    req_pc;
  logic [31:0]    q_pc   [QDEPTH];
  logic [31:0]    q_inst [QDEPTH];
  logic           q_adef [QDEPTH];
  logic [QAW-1:0] head, tail;
  logic [CW-1:0]  count;
  logic [31:0]    f_pc   [MAX_OUTSTANDING];
  logic [FAW-1:0] f_head, f_tail;
  logic [IW-1:0]  inflight;
  logic [DW-1:0]  discard_cnt;
  logic           adef_hold;

  logic [CW:0]    occupancy;
  logic [DW:0]    discard_sum;
  logic           req_fire, adef_push, ret, ret_push, q_push, q_pop, q_empty;

  // Issue credit counts queued entries plus returns still owed, so every return has a slot.
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight);
  assign q_empty   = (count == '0);

  assign fetch_pc_vrtl  = req_pc;
  assign inst_sram_addr = fetch_pa;
  assign inst_sram_req  = ~reset & ~redirect_valid & ~fetch_stall & ~adef_hold &
                          (req_pc[1:0] == 2'b00) & (inflight < MAX_IF) & (occupancy < QFULL);

  assign req_fire  = inst_sram_req & inst_sram_addr_ok;
  assign adef_push = ~redirect_valid & ~adef_hold & (req_pc[1:0] != 2'b00) & (occupancy < QFULL);
  assign ret       = inst_sram_data_ok & ~redirect_valid & (discard_cnt == '0) & (inflight != '0);
  assign q_pop     = ~q_empty & ds_allowin & ~redirect_valid;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass   = ret & q_empty;
  assign ret_push = ret & ~(bypass & ds_allowin);
`else
  assign ret_push = ret;
`endif
  assign q_push = ret_push | adef_push;

  // Everything still owed by the SRAM at a redirect becomes stale, less the one returning now.
  assign discard_sum = {1'b0, discard_cnt} + (DW + 1)'(inflight)
                     - (DW + 1)'(inst_sram_data_ok & ((discard_cnt != '0) | (inflight != '0)));

  always_comb begin
    fs2ds_valid = 1'b0;
    fs_pc       = '0;
    fs_inst     = '0;
    fs_adef     = 1'b0;
    if (!q_empty) begin
      fs2ds_valid = 1'b1;
      fs_pc       = q_pc[head];
      fs_inst     = q_inst[head];
      fs_adef     = q_adef[head];
    end
`ifdef IFQ_BYPASS_EN
    else if (bypass) begin
      fs2ds_valid = 1'b1;
      fs_pc       = f_pc[f_head];
      fs_inst     = inst_sram_rdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (req_fire) f_pc[f_tail] <= req_pc;
    if (q_push) begin
      q_pc[tail]   <= ret_push ? f_pc[f_head] : req_pc;
      q_inst[tail] <= ret_push ? inst_sram_rdata : 32'h0;
      q_adef[tail] <= ~ret_push;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pc      <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      f_head      <= '0;
      f_tail      <= '0;
      inflight    <= '0;
      discard_cnt <= '0;
      adef_hold   <= 1'b0;
    end else if (redirect_valid) begin
      req_pc      <= redirect_pc;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      f_head      <= '0;
      f_tail      <= '0;
      inflight    <= '0;
      discard_cnt <= discard_sum[DW-1:0];
      adef_hold   <= 1'b0;
    end else begin
      if (req_fire) begin
        f_tail <= (f_tail == FLAST) ? '0 : f_tail + FAW'(1);
        req_pc <= req_pc + 32'd4;
      end
      if (ret) f_head <= (f_head == FLAST) ? '0 : f_head + FAW'(1);
      if (inst_sram_data_ok && (discard_cnt != '0)) discard_cnt <= discard_cnt - DW'(1);
      inflight <= inflight + IW'(req_fire) - IW'(ret);
      if (adef_push) adef_hold <= 1'b1;
      if (q_push) tail <= tail + QAW'(1);
      if (q_pop) head <= head + QAW'(1);
      count <= count + CW'(q_push) - CW'(q_pop);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-level reference model checked every cycle, directed and random stimulus.
module tb_if_fetch_queue;
  localparam int          QD     = 4;
  localparam int          MO     = 2;
  localparam logic [31:0] RPC    = 32'h1C00_0000;
  localparam logic [31:0] PA_XOR = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset, inst_sram_req, addr_ok, data_ok, fetch_stall, redirect_valid, ds_allowin;
  logic        fs2ds_valid, fs_adef;
  logic [31:0] inst_sram_addr, rdata, fetch_pc_vrtl, fetch_pa, redirect_pc, fs_pc, fs_inst;

  always #5 clk = ~clk;
  assign fetch_pa = fetch_pc_vrtl ^ PA_XOR;

  if_fetch_queue #(.QDEPTH(QD), .MAX_OUTSTANDING(MO), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata),
    .fetch_pc_vrtl(fetch_pc_vrtl), .fetch_pa(fetch_pa), .fetch_stall(fetch_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ds_allowin(ds_allowin),
    .fs2ds_valid(fs2ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_adef(fs_adef)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic adef; } ent_t;

  // Reference model: decode queue, in-flight PCs, stale-return count, fetch PC, halt flag.
  ent_t        mq[$];
  logic [31:0] mif[$];
  int          mdisc = 0;
  logic [31:0] mpc = RPC;
  bit          mhold = 0;
  bit          m_r;
  int          m_occ;
  ent_t        m_e;

  logic [31:0] mem_a[$];
  int          mem_r[$];
  int          cyc = 0, last_rdy = 0, lat_min = 1, lat_max = 1, acc_cnt = 0, rd;
  logic [31:0] dlv[$];
  int          total = 0, bad = 0;
  bit          rnd = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic bit exp_req();
    return !reset && !redirect_valid && !fetch_stall && !mhold && (mpc[1:0] == 2'b00) &&
           (mif.size() < MO) && (mq.size() + mif.size() < QD);
  endfunction

  function automatic logic [31:0] dl(input int i);
    if (i < dlv.size()) return dlv[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("rst_req", 32'(inst_sram_req), 32'd0);
      check("rst_vld", 32'(fs2ds_valid), 32'd0);
      check("rst_pc", fs_pc, 32'd0);
      check("rst_inst", fs_inst, 32'd0);
      check("rst_adef", 32'(fs_adef), 32'd0);
    end else begin
      check("req", 32'(inst_sram_req), 32'(exp_req()));
      check("vrtl", fetch_pc_vrtl, mpc);
      if (exp_req()) check("addr", inst_sram_addr, mpc ^ PA_XOR);
      check("vld", 32'(fs2ds_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("pc", fs_pc, mq[0].pc);
        check("inst", fs_inst, mq[0].inst);
        check("adef", 32'(fs_adef), 32'(mq[0].adef));
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      mq.delete(); mif.delete(); mdisc = 0; mpc = RPC; mhold = 0;
    end else begin
      m_r = exp_req();
      m_occ = mq.size() + mif.size();
      if (redirect_valid) begin
        mdisc = mdisc + mif.size() - ((data_ok && (mdisc + mif.size() > 0)) ? 1 : 0);
        mq.delete(); mif.delete(); mpc = redirect_pc; mhold = 0;
      end else begin
        if (mq.size() > 0 && ds_allowin) void'(mq.pop_front());
        if (data_ok) begin
          if (mdisc > 0) mdisc--;
          else if (mif.size() > 0) begin
            m_e.pc = mif.pop_front(); m_e.inst = rdata; m_e.adef = 1'b0;
            mq.push_back(m_e);
          end
        end
        if (m_r && addr_ok) begin
          mif.push_back(mpc);
          mpc = mpc + 32'd4;
        end else if (mpc[1:0] != 2'b00 && !mhold && m_occ < QD) begin
          m_e.pc = mpc; m_e.inst = 32'h0; m_e.adef = 1'b1;
          mq.push_back(m_e);
          mhold = 1;
        end
      end
    end
  end

  // SRAM: in-order returns with latency lat_min..lat_max cycles after acceptance.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mem_a.delete(); mem_r.delete(); last_rdy = 0;
    end else begin
      if (data_ok && mem_a.size() > 0) begin
        void'(mem_a.pop_front()); void'(mem_r.pop_front());
      end
      if (inst_sram_req && addr_ok) begin
        acc_cnt++;
        rd = cyc + int'($urandom_range(lat_min, lat_max)) - 1;
        if (rd < last_rdy) rd = last_rdy;
        last_rdy = rd;
        mem_a.push_back(inst_sram_addr);
        mem_r.push_back(rd);
      end
    end
  end

  always @(posedge clk)
    if (!reset && fs2ds_valid && ds_allowin && !redirect_valid) dlv.push_back(fs_pc);

  task automatic step();
    @(posedge clk); #1;
    if (rnd) begin
      ds_allowin     = ($urandom_range(0, 99) < 70);
      addr_ok        = ($urandom_range(0, 99) < 75);
      fetch_stall    = ($urandom_range(0, 99) < 10);
      redirect_valid = ($urandom_range(0, 99) < 4) && (mdisc <= MO);
      redirect_pc    = RPC + 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
    end
    data_ok = (mem_r.size() > 0) && (mem_r[0] <= cyc);
    rdata   = data_ok ? inst_of(mem_a[0]) : $urandom;
  endtask

  initial begin
    reset = 1'b0; addr_ok = 0; data_ok = 0; rdata = 0; fetch_stall = 0;
    redirect_valid = 0; redirect_pc = 0; ds_allowin = 0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lit_rst_req", 32'(inst_sram_req), 32'd0);
    check("lit_rst_vld", 32'(fs2ds_valid), 32'd0);

    // Streaming after reset: one request and one delivery per cycle.
    @(posedge clk); #1;
    reset = 1'b0; ds_allowin = 1; addr_ok = 1;
    dlv.delete();
    @(negedge clk);
    check("lit_first_req", 32'(inst_sram_req), 32'd1);
    check("lit_first_vrtl", fetch_pc_vrtl, 32'h1C00_0000);
    check("lit_first_addr", inst_sram_addr, 32'h5C00_0000);
    repeat (12) step();
    check("lit_stream0", dl(0), 32'h1C00_0000);
    check("lit_stream1", dl(1), 32'h1C00_0004);
    check("lit_stream5", dl(5), 32'h1C00_0014);
    check("lit_stream_cnt", 32'(dlv.size()), 32'd10);

    // Decode back-pressure: queue plus in-flight credit stops at QDEPTH requests.
    step(); redirect_valid = 1; redirect_pc = 32'h1C00_0200; ds_allowin = 0;
    step(); redirect_valid = 0; dlv.delete(); acc_cnt = 0;
    repeat (12) step();
    @(negedge clk);
    check("lit_bp_acc", 32'(acc_cnt), 32'd4);
    check("lit_bp_req", 32'(inst_sram_req), 32'd0);
    check("lit_bp_head", fs_pc, 32'h1C00_0200);
    step(); ds_allowin = 1;
    repeat (10) step();
    for (int i = 0; i < 5; i++) check("lit_bp_order", dl(i), 32'h1C00_0200 + 32'(4 * i));

    // Redirect with two requests in flight: both stale returns dropped.
    lat_min = 3; lat_max = 3;
    repeat (4) step();
    step(); redirect_valid = 1; redirect_pc = 32'h1C00_0100;
    step(); redirect_valid = 0; dlv.delete();
    repeat (12) step();
    check("lit_rd2_first", dl(0), 32'h1C00_0100);
    check("lit_rd2_second", dl(1), 32'h1C00_0104);

    // Redirect coinciding with the only outstanding return.
    lat_min = 1; lat_max = 1; fetch_stall = 1;
    repeat (6) step();
    step(); redirect_valid = 1; redirect_pc = 32'h1C00_0300; fetch_stall = 0;
    step(); redirect_valid = 0;
    step(); fetch_stall = 1; redirect_valid = 1; redirect_pc = 32'h1C00_0400;
    step(); redirect_valid = 0; fetch_stall = 0; dlv.delete();
    repeat (8) step();
    check("lit_same_first", dl(0), 32'h1C00_0400);

    // Misaligned redirect: one exception entry, fetch halted.
    step(); redirect_valid = 1; redirect_pc = 32'h1C00_0102; ds_allowin = 0;
    step(); redirect_valid = 0;
    repeat (5) step();
    @(negedge clk);
    check("lit_adef_vld", 32'(fs2ds_valid), 32'd1);
    check("lit_adef_pc", fs_pc, 32'h1C00_0102);
    check("lit_adef_inst", fs_inst, 32'd0);
    check("lit_adef_flag", 32'(fs_adef), 32'd1);
    check("lit_adef_req", 32'(inst_sram_req), 32'd0);
    step(); redirect_valid = 1; redirect_pc = RPC; ds_allowin = 1;
    step(); redirect_valid = 0;

    // Random traffic against the model.
    lat_min = 1; lat_max = 4; rnd = 1;
    repeat (3000) step();

    // Asynchronous reset with requests in flight.
    rnd = 0;
    step(); redirect_valid = 0; fetch_stall = 0; addr_ok = 1; ds_allowin = 1;
    lat_min = 3; lat_max = 3;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    check("lit_mid_req", 32'(inst_sram_req), 32'd0);
    check("lit_mid_vld", 32'(fs2ds_valid), 32'd0);
    check("lit_mid_pc", fs_pc, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check("lit_post_req", 32'(inst_sram_req), 32'd1);
    check("lit_post_vrtl", fetch_pc_vrtl, 32'h1C00_0000);
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end with multiple outstanding inst-SRAM requests and an instruction queue toward decode. It sits between the IF-stage PC redirect sources (exception, ertn, branch, already merged upstream) and the decode stage. It replaces single-buffer fetch with a QDEPTH-entry queue so decode back-pressure does not stall the SRAM request stream. Stale returns after a redirect are tracked and dropped by counter rather than by a one-shot flag.

## Interface
- QDEPTH, 4, instruction queue entries; power of two, ≥2
- MAX_OUTSTANDING, 2, max addr_ok-accepted requests awaiting data_ok; 1..QDEPTH
- RESET_PC, 32'h1C00_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- inst_sram_req  out  1  request valid
- inst_sram_addr  out  32  physical fetch address (= fetch_pa)
- inst_sram_addr_ok  in  1  request accepted this cycle
- inst_sram_data_ok  in  1  rdata valid this cycle, in request order
- inst_sram_rdata  in  32  returned instruction
- fetch_pc_vrtl  out  32  virtual PC of next request, to translation
- fetch_pa  in  32  combinational translation of fetch_pc_vrtl
- fetch_stall  in  1  suppress new requests (e.g. branch unresolved)
- redirect_valid  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  new fetch PC
- ds_allowin  in  1  decode accepts head entry
- fs2ds_valid  out  1  head entry valid
- fs_pc  out  32  head entry PC
- fs_inst  out  32  head entry instruction (0 when fs_adef)
- fs_adef  out  1  head entry has misaligned-PC exception

## Operation
- Registers: req_pc, queue (pc, inst, adef) with head/tail pointers and count, in-flight PC FIFO (MAX_OUTSTANDING deep), inflight count, discard_cnt, adef_hold.
- inst_sram_req = ~reset & ~redirect_valid & ~fetch_stall & ~adef_hold & (req_pc[1:0]==0) & (inflight < MAX_OUTSTANDING) & (count + inflight < QDEPTH); uses registered counts only (conservative, no same-cycle pop credit).
- req & addr_ok: push req_pc into in-flight FIFO, inflight+1, req_pc += 4 (32-bit wrap).
- req_pc[1:0]≠0, no redirect, space in queue: push entry {req_pc, 0, adef=1}, set adef_hold; no SRAM request; fetching halts until redirect.
- data_ok with discard_cnt>0: drop data, discard_cnt−1. Otherwise pop in-flight PC, push {pc, rdata, 0}, inflight−1.
- Pop head when fs2ds_valid & ds_allowin.
- redirect_valid (highest priority): req_pc←redirect_pc, queue and in-flight FIFO emptied, adef_hold←0, discard_cnt ← discard_cnt + inflight − (data_ok this cycle ? 1 : 0); inflight←0; head pop this cycle ignored.
- data_ok when inflight==0 and discard_cnt==0: protocol error, ignored.

## Timing
- Reset (async): req_pc=RESET_PC, all counts/pointers/discard_cnt/adef_hold=0; outputs inst_sram_req=0, fs2ds_valid=0, fs_pc/fs_inst=0, fs_adef=0.
- First inst_sram_req in first cycle after reset deasserts.
- Issue throughput: one request/cycle while credits allow.
- data_ok to fs2ds_valid: 1 cycle (entry registered) without bypass; see Configuration.
- Redirect in cycle N: no req in N; req for redirect_pc earliest at N+1; fs2ds_valid=0 at N+1.
- Queue full (count=QDEPTH): req deasserted; simultaneous push+pop legal at any count.
- Back-to-back redirects: discard_cnt accumulates; width clog2(2*MAX_OUTSTANDING+1).

## Configuration
- IFQ_BYPASS_EN defined: when queue empty and a non-discarded data_ok arrives, fs2ds_valid/fs_pc/fs_inst driven combinationally from in-flight head and rdata same cycle; if ds_allowin, entry not written to queue. Zero-latency fetch.
- Undefined: every return written to queue first; fs2ds_valid earliest cycle after data_ok; no rdata→decode combinational path.

## Test plan
- Reset, ds_allowin=1, addr_ok always, data_ok 1 cycle after addr_ok -> requests 1C000000, 1C000004, 1C000008…; decode sees same PCs in order, one/cycle steady state.
- ds_allowin=0, QDEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 requests accepted, req then stays 0; ds_allowin=1 resumes, no loss/duplication.
- Two requests in flight, redirect to 1C000100 -> next 2 data_ok dropped (discard_cnt 2→0), first delivered fs_pc=1C000100.
- Redirect in same cycle as data_ok with 1 in flight -> discard_cnt=0, data dropped, no stale entry.
- redirect_pc=1C000102 -> no SRAM request, one entry fs_adef=1 fs_pc=1C000102 fs_inst=0, fetch halted until next redirect.
- Reset asserted mid-stream with 2 in flight -> outputs zero immediately; after release first req at 1C000000.
